div_mod_seq: RTL and testbench

Iterative signed divider that inverts the team's multiply-add datapath: for each accepted dividend/divisor pair it returns quotient and remainder such that dividend = quotient * divisor + remainder. It sits downstream of the DSP multiply-add pipelines, for example normalising accumulated products. It has valid/ready handshakes on both sides and the same clock-enable stall semantics as those pipelines. It computes one quotient bit per enabled cycle with a single shared subtractor.

---
 rtl/div_mod_seq.sv | 147 ++++++++++++++
 tb/tb_div_mod_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_mod_seq.sv
// div_mod_seq: iterative signed divider (restoring, one quotient bit per
// enabled cycle). Returns quot/rem with dividend = quot*divisor + rem,
// truncating toward zero. Valid/ready on both sides, clock-enable stalls.
`timescale 1ns/1ps
module div_mod_seq #(
  parameter int NW = 48,
  parameter int DW = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [NW-1:0] dividend,
  input  logic signed [DW-1:0] divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [NW-1:0] quot,
  output logic signed [DW-1:0] rem,
  output logic                 dz,
  output logic                 ovf
);

  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic signed [NW-1:0] MIN_N = {1'b1, {(NW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   sn_q;      // dividend sign
  logic                   sd_q;      // divisor sign
  logic                   ovfp_q;    // -2^(NW-1) / -1 detected at accept
  logic [NW-1:0]          nq_q;      // dividend magnitude, shifts out MSB first, quotient shifts in
  logic [DW-1:0]          dmag_q;    // divisor magnitude (2^(DW-1) fits unsigned)
  logic [DW:0]            pr_q;      // partial remainder
  logic [DW:0]            pr_d;
  logic [NW-1:0]          nq_d;
  logic [DW+1:0]          trial;
  logic [DW+1:0]          sub;
  logic                   ge;

  logic                   out_valid_q;
  logic signed [NW-1:0]   quot_q;
  logic signed [DW-1:0]   rem_q;
  logic                   dz_q;
  logic                   ovf_q;

  // Magnitude of the dividend, computed in NW+1 bits so -2^(NW-1) is exact.
  function automatic logic [NW-1:0] abs_n(input logic signed [NW-1:0] v);
    logic [NW:0] e;
    e = {v[NW-1], v};
    if (v[NW-1]) e = -e;
    return e[NW-1:0];
  endfunction

  // Magnitude of the divisor, computed in DW+1 bits so -2^(DW-1) is exact.
  function automatic logic [DW-1:0] abs_d(input logic signed [DW-1:0] v);
    logic [DW:0] e;
    e = {v[DW-1], v};
    if (v[DW-1]) e = -e;
    return e[DW-1:0];
  endfunction

  // Apply sign to a quotient magnitude; 2^(NW-1) negated or not wraps to MIN_N.
  function automatic logic [NW-1:0] sgn_n(input logic [NW-1:0] m, input logic s);
    return s ? -m : m;
  endfunction

  // Apply sign to a remainder magnitude; |rem| < |divisor| keeps it in range.
  function automatic logic [DW-1:0] sgn_d(input logic [DW-1:0] m, input logic s);
    return s ? -m : m;
  endfunction

  assign in_ready  = (state_q == IDLE) & ce & rst_n;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    trial = {pr_q, nq_q[NW-1]};
    sub   = trial - {2'b00, dmag_q};
    ge    = ~sub[DW+1];
    pr_d  = ge ? sub[DW:0] : trial[DW:0];
    nq_d  = {nq_q[NW-2:0], ge};
  end

  // Control FSM with registered results; output handshake ignores ce.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (state_q == DONE && out_valid_q && out_ready) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sn_q   <= dividend[NW-1];
            sd_q   <= divisor[DW-1];
            nq_q   <= abs_n(dividend);
            dmag_q <= abs_d(divisor);
            pr_q   <= '0;
            cnt_q  <= CW'(NW-1);
            ovfp_q <= (dividend == MIN_N) && (divisor == '1);
            if (divisor == '0) begin
              quot_q  <= '0;
              rem_q   <= '0;
              dz_q    <= 1'b1;
              ovf_q   <= 1'b0;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          pr_q <= pr_d;
          nq_q <= nq_d;
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FIX: begin
          quot_q  <= sgn_n(nq_q, sn_q ^ sd_q);
          rem_q   <= sgn_d(pr_q[DW-1:0], sn_q);
          dz_q    <= 1'b0;
          ovf_q   <= ovfp_q;
          state_q <= DONE;
        end
        DONE: begin
          // Results are already in place; publish them on this edge.
          if (!out_valid_q) out_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mod_seq.sv
// tb_div_mod_seq: directed and randomized checks of div_mod_seq against an
// arithmetic reference model (truncating signed division).
`timescale 1ns/1ps
module tb_div_mod_seq;

  localparam int NW = 48;
  localparam int DW = 18;
  localparam longint MINN = -(longint'(1) <<< (NW-1));
  localparam longint MAXN = (longint'(1) <<< (NW-1)) - 1;
  localparam longint MIND = -(longint'(1) <<< (DW-1));
  localparam longint MAXD = (longint'(1) <<< (DW-1)) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 ce;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [NW-1:0] dividend;
  logic signed [DW-1:0] divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [NW-1:0] quot;
  logic signed [DW-1:0] rem;
  logic                 dz;
  logic                 ovf;

  int n_chk  = 0;
  int n_fail = 0;

  div_mod_seq #(.NW(NW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .dz(dz), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, got %0d checks, expected completion", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapn(input longint v);
    logic signed [NW-1:0] t;
    t = v[NW-1:0];
    return longint'(t);
  endfunction

  function automatic longint wrapd(input longint v);
    logic signed [DW-1:0] t;
    t = v[DW-1:0];
    return longint'(t);
  endfunction

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // ce_mode: 0 = ce high, 1 = random ce, 2 = ce low for 5 cycles mid-calculation.
  // hold: cycles out_ready stays low after out_valid (<0 = random).
  // exp_lat: required accept-to-out_valid latency (0 = not checked).
  task automatic do_op(input longint a, input longint b, input int ce_mode,
                       input int hold, input int exp_lat);
    longint eq, er, gq, gr;
    logic   edz, eovf, acc;
    int     lat, h;
    edz  = (b == 0);
    eovf = (a == MINN) && (b == -1);
    if (edz) begin
      eq = 0;
      er = 0;
    end else begin
      eq = wrapn(a / b);
      er = a % b;
    end
    dividend = a[NW-1:0];
    divisor  = b[DW-1:0];
    in_valid = 1'b1;
    out_ready = 1'b0;
    acc = 1'b0;
    for (int g = 0; g < 200 && !acc; g++) begin
      ce = (ce_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    dividend = NW'({$urandom, $urandom});
    divisor  = DW'($urandom);
    if (!acc) begin
      chk("accept", acc, 1);
      return;
    end
    lat = 0;
    while (!out_valid && lat < 300) begin
      case (ce_mode)
        1:       ce = ($urandom_range(0, 3) != 0);
        2:       ce = !(lat >= 10 && lat < 15);
        default: ce = 1'b1;
      endcase
      @(posedge clk); #1;
      lat++;
    end
    chk("out_valid", out_valid, 1);
    if (!out_valid) return;
    if (exp_lat > 0) chk("latency", lat, exp_lat);
    chk("quot", quot, eq);
    chk("rem", rem, er);
    chk("dz", dz, longint'(edz));
    chk("ovf", ovf, longint'(eovf));
    gq = longint'(quot);
    gr = longint'(rem);
    if (!edz && !eovf) begin
      chk("identity", gq * b + gr, a);
      chk("rem_mag", absl(gr) < absl(b), 1);
      chk("rem_sign", (gr == 0) || ((gr < 0) == (a < 0)), 1);
    end
    h = (hold < 0) ? $urandom_range(0, 3) : hold;
    for (int i = 0; i < h; i++) begin
      if (ce_mode == 1) ce = ($urandom_range(0, 1) != 0);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_quot", quot, eq);
      chk("hold_rem", rem, er);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ce = 1'b1;
    #1;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
  endtask

  initial begin
    longint a, b;
    logic   seen;
    rst_n     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dz", dz, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Sign combinations
    do_op(100, 7, 0, 0, 50);
    do_op(-100, 7, 0, 0, 50);
    do_op(100, -7, 0, 0, 50);
    do_op(-100, -7, 0, 0, 50);

    // Extremes, divide by zero, overflow
    do_op(MAXN, MIND, 0, 0, 50);
    do_op(MINN, MIND, 0, 0, 50);
    do_op(5, MAXD, 0, 0, 50);
    do_op(-5, MIND, 0, 0, 50);
    do_op(12345, 0, 0, 0, 1);
    do_op(MINN, -1, 0, 0, 50);
    do_op(MINN, 1, 0, 0, 50);

    // Stalls
    do_op(1000003, -77, 2, 0, 55);
    do_op(-99999, 123, 0, 10, 50);

    // Reset in the middle of a calculation
    dividend = 1000;
    divisor  = 3;
    in_valid = 1'b1;
    ce       = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_quot", quot, 0);
    chk("mid_rst_rem", rem, 0);
    chk("mid_rst_dz", dz, 0);
    chk("mid_rst_ovf", ovf, 0);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("aborted_no_output", seen, 0);
    do_op(9, 3, 0, 0, 50);

    // Randomized pairs with random ce and out_ready timing
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       a = longint'($urandom_range(0, 2000)) - 1000;
        1:       a = ($urandom_range(0, 1) != 0) ? MINN : MAXN;
        default: a = wrapn({$urandom, $urandom});
      endcase
      case ($urandom_range(0, 7))
        0:       b = 0;
        1:       b = -1;
        2:       b = ($urandom_range(0, 1) != 0) ? MIND : MAXD;
        3:       b = longint'($urandom_range(0, 40)) - 20;
        default: b = wrapd(longint'($urandom));
      endcase
      do_op(a, b, 1, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
